// File: rtl/buffered_stream_router.sv
// buffered_stream_router: steers a valid/ready stream to one of NUM_OUT
// channels by address, or to every channel at once when bcast is set.
// Each channel has its own first-word-fall-through FIFO, so one stalled
// consumer holds up only the traffic addressed to it.
module buffered_stream_router #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [$clog2(NUM_OUT)-1:0]    addr,
    input  logic                          bcast,
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
    output logic [NUM_OUT-1:0]            dout_valid,
    input  logic [NUM_OUT-1:0]            dout_ready,
    output logic                          drop
);

    localparam int AW = $clog2(NUM_OUT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [AW:0]   NUM_OUT_C = (AW + 1)'(NUM_OUT);

    logic [DATA_WIDTH-1:0] mem_q [NUM_OUT][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [NUM_OUT][FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q [NUM_OUT];
    logic [PW-1:0]         rd_ptr_d [NUM_OUT];
    logic [PW-1:0]         wr_ptr_q [NUM_OUT];
    logic [PW-1:0]         wr_ptr_d [NUM_OUT];
    logic [CW-1:0]         count_q  [NUM_OUT];
    logic [CW-1:0]         count_d  [NUM_OUT];
    logic                  drop_q;
    logic                  drop_d;

    logic [NUM_OUT-1:0]    full;
    logic [NUM_OUT-1:0]    empty;
    logic [NUM_OUT-1:0]    sel;
    logic [NUM_OUT-1:0]    push;
    logic [NUM_OUT-1:0]    pop;
    logic                  addr_in_range;
    logic                  accept;

    // Per-channel status flags and destination decode (bcast selects every channel)
    always_comb begin
        full          = '0;
        empty         = '0;
        sel           = '0;
        addr_in_range = ({1'b0, addr} < NUM_OUT_C);
        for (int i = 0; i < NUM_OUT; i++) begin
            full[i]  = (count_q[i] == DEPTH_C);
            empty[i] = (count_q[i] == '0);
            sel[i]   = bcast || (addr == AW'(i));
        end
    end

    // Input handshake: ready looks only at FIFO fullness, never at dout_ready,
    // so a full FIFO cannot take a word even in a cycle where it is popped
    always_comb begin
        if (reset) begin
            din_ready = 1'b0;
        end else if (bcast) begin
            din_ready = ~|full;
        end else if (addr_in_range) begin
            din_ready = ~|(full & sel);
        end else begin
            din_ready = 1'b1;
        end
        accept = din_valid && din_ready;
        push   = {NUM_OUT{accept}} & sel;
        pop    = ~empty & dout_ready;
        drop_d = accept && !bcast && !addr_in_range;
    end

    // FIFO next state: write at wr_ptr, advance pointers, track occupancy
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = din;
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // State registers; reset flushes every FIFO and clears storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            drop_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Output heads: FIFO head when non-empty, forced to zero when empty
    always_comb begin
        dout       = '0;
        dout_valid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            dout_valid[i] = ~empty[i];
            if (!empty[i]) begin
                dout[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    assign drop = drop_q;

endmodule
